riscvsys_evmon: RTL and testbench
=================================

RISCVSYS_EVMON -- requirements
Module: riscvsys_evmon

Interface
REQ-001 Parameter CNT_W, default 32, width of retired-instruction counter.
REQ-002 i_clk  input  1  clock; all state updates on rising edge.
REQ-003 i_rst  input  1  reset, synchronous, active-low.
REQ-004 i_instr_lui, _auipc, _jal, _jalr  input  1 each  one-hot decode flags, upper-immediate/jump class.
REQ-005 i_instr_beq, _bne, _blt, _bge, _bltu, _bgeu  input  1 each  branch decode flags.
REQ-006 i_instr_lb, _lh, _lw, _lbu, _lhu, _sb, _sh, _sw  input  1 each  load/store decode flags.
REQ-007 i_instr_addi, _slti, _sltiu, _xori, _ori, _andi, _slli, _srli, _srai  input  1 each  ALU-immediate decode flags.
REQ-008 i_instr_add, _sub, _sll, _slt, _sltu, _xor, _srl, _sra, _or, _and  input  1 each  ALU-register decode flags.
REQ-009 i_instr_rdcycle, _rdcycleh, _rdinstr, _rdinstrh, _ecall_ebreak  input  1 each  counter/system decode flags.
REQ-010 i_instr_getq, _setq, _retirq, _maskirq, _waitirq, _timer, _trap  input  1 each  IRQ-extension/trap decode flags.
REQ-011 i_pc  input  32  PC of current instruction; i_next_pc  input  32  next PC.
REQ-012 i_dbg_next  input  1  single-cycle strobe: decode flags and PCs describe a newly issued instruction.
REQ-013 ev_<m>  output  1 each  one event per decode flag, same mnemonic (ev_lui ... ev_trap, 49 outputs, incl. ev_add).
REQ-014 ev_branch, ev_jump, ev_load, ev_store, ev_alu, ev_system, ev_irq  output  1 each  class events.
REQ-015 ev_unknown  output  1  issue with no decode flag set (e.g. PCPI mul/div).
REQ-016 ev_multi  output  1  issue with more than one decode flag set.
REQ-017 ev_misalign  output  1  issue with i_pc[0]==1.
REQ-018 ev_nonseq  output  1  issue where i_next_pc is neither i_pc+2 nor i_pc+4.
REQ-019 o_retired  output  CNT_W  count of issue strobes since reset.

Function
REQ-020 issue = i_dbg_next; decode flags and PCs are ignored when issue is 0.
REQ-021 ev_<m> SHALL equal issue & i_instr_<m>, registered: asserted exactly one cycle after the sampling edge, high for one cycle per issue.
REQ-022 Class events are the registered OR of their members under issue: branch = 6 branch flags; jump = jal|jalr; load = 5 loads; store = 3 stores; alu = lui|auipc|9 ALU-imm|10 ALU-reg; system = rdcycle|rdcycleh|rdinstr|rdinstrh|ecall_ebreak; irq = getq|setq|retirq|maskirq|waitirq|timer.
REQ-023 ev_unknown, ev_multi, ev_misalign, ev_nonseq are registered with the same one-cycle latency.
REQ-024 PC sums use 32-bit modulo arithmetic (wrap at 0xFFFF_FFFF).
REQ-025 o_retired increments by 1 on each cycle with issue; wraps to 0 at 2^CNT_W-1; no saturation.
REQ-026 Back-to-back issues on consecutive cycles produce back-to-back event pulses; no events are dropped or merged.
REQ-027 Multi-hot input: every matching ev_<m> and class event asserts, plus ev_multi.

Reset
REQ-028 While i_rst==0 at a rising edge, all ev_* outputs clear to 0 and o_retired to 0 on that edge; inputs are ignored.
REQ-029 An issue sampled on the edge where reset is asserted produces no event and no count; first event possible one cycle after the first edge with i_rst==1.

Structure
REQ-030 Shared package holds the mnemonic enumeration (49 entries, index order as REQ-004..REQ-010) and class-mask constants.
REQ-031 Per-flag registering uses one generic sub-module evmon_pulse (input bit + issue -> registered pulse), replicated per event.
REQ-032 Purely monitor logic: no combinational input-to-output path.

Verification
REQ-033 Issue with i_instr_add=1, i_pc=0x100, i_next_pc=0x104 -> next cycle ev_add=1, ev_alu=1, all others 0; o_retired 0->1.
REQ-034 Issue beq with i_pc=0x200, i_next_pc=0x180 -> ev_beq=1, ev_branch=1, ev_nonseq=1; i_next_pc=0x202 -> ev_nonseq=0.
REQ-035 i_instr_lw=1 held high with i_dbg_next=0 for 10 cycles -> no events; o_retired unchanged.
REQ-036 Issue with no flags, i_pc=0x101 -> ev_unknown=1, ev_misalign=1; two flags (sw, xori) -> ev_sw, ev_xori, ev_store, ev_alu, ev_multi all 1.
REQ-037 Issue on 5 consecutive cycles, then i_rst=0 mid-stream -> 5 pulses, o_retired=5, then outputs and counter 0 on the reset edge.
REQ-038 CNT_W=4, 17 issues -> o_retired=1 (wrap).

Source files
------------

// File: rtl/riscvsys_evmon_pkg.sv
// Shared definitions for the instruction event monitor: mnemonic indices,
// event vector layout and per-class decode masks.
package riscvsys_evmon_pkg;

  typedef enum logic [5:0] {
    M_LUI, M_AUIPC, M_JAL, M_JALR,
    M_BEQ, M_BNE, M_BLT, M_BGE, M_BLTU, M_BGEU,
    M_LB, M_LH, M_LW, M_LBU, M_LHU, M_SB, M_SH, M_SW,
    M_ADDI, M_SLTI, M_SLTIU, M_XORI, M_ORI, M_ANDI, M_SLLI, M_SRLI, M_SRAI,
    M_ADD, M_SUB, M_SLL, M_SLT, M_SLTU, M_XOR, M_SRL, M_SRA, M_OR, M_AND,
    M_RDCYCLE, M_RDCYCLEH, M_RDINSTR, M_RDINSTRH, M_ECALL_EBREAK,
    M_GETQ, M_SETQ, M_RETIRQ, M_MASKIRQ, M_WAITIRQ, M_TIMER, M_TRAP
  } mnem_e;

  localparam int N_MNEM = 49;

  // Event vector: per-mnemonic events in the low bits, then class and status events.
  localparam int EV_BRANCH   = N_MNEM;
  localparam int EV_JUMP     = N_MNEM + 1;
  localparam int EV_LOAD     = N_MNEM + 2;
  localparam int EV_STORE    = N_MNEM + 3;
  localparam int EV_ALU      = N_MNEM + 4;
  localparam int EV_SYSTEM   = N_MNEM + 5;
  localparam int EV_IRQ      = N_MNEM + 6;
  localparam int EV_UNKNOWN  = N_MNEM + 7;
  localparam int EV_MULTI    = N_MNEM + 8;
  localparam int EV_MISALIGN = N_MNEM + 9;
  localparam int EV_NONSEQ   = N_MNEM + 10;
  localparam int N_EV        = N_MNEM + 11;

  typedef logic [N_MNEM-1:0] mnem_vec_t;
  typedef logic [N_EV-1:0]   ev_vec_t;

  function automatic mnem_vec_t mask_range(mnem_e lo, mnem_e hi);
    mnem_vec_t m;
    m = '0;
    for (int i = int'(lo); i <= int'(hi); i++) m[i] = 1'b1;
    return m;
  endfunction

  localparam mnem_vec_t MASK_BRANCH = mask_range(M_BEQ, M_BGEU);
  localparam mnem_vec_t MASK_JUMP   = mask_range(M_JAL, M_JALR);
  localparam mnem_vec_t MASK_LOAD   = mask_range(M_LB, M_LHU);
  localparam mnem_vec_t MASK_STORE  = mask_range(M_SB, M_SW);
  localparam mnem_vec_t MASK_ALU    = mask_range(M_LUI, M_AUIPC) | mask_range(M_ADDI, M_AND);
  localparam mnem_vec_t MASK_SYSTEM = mask_range(M_RDCYCLE, M_ECALL_EBREAK);
  localparam mnem_vec_t MASK_IRQ    = mask_range(M_GETQ, M_TIMER);

endpackage

// File: rtl/riscvsys_evmon_if.sv
// Decode/PC issue bus and event outputs of the monitor; named signals on the
// core side, packed vectors on the monitor side.
interface riscvsys_evmon_if;
  import riscvsys_evmon_pkg::*;

  logic i_instr_lui, i_instr_auipc, i_instr_jal, i_instr_jalr;
  logic i_instr_beq, i_instr_bne, i_instr_blt, i_instr_bge, i_instr_bltu, i_instr_bgeu;
  logic i_instr_lb, i_instr_lh, i_instr_lw, i_instr_lbu, i_instr_lhu, i_instr_sb, i_instr_sh, i_instr_sw;
  logic i_instr_addi, i_instr_slti, i_instr_sltiu, i_instr_xori, i_instr_ori, i_instr_andi;
  logic i_instr_slli, i_instr_srli, i_instr_srai;
  logic i_instr_add, i_instr_sub, i_instr_sll, i_instr_slt, i_instr_sltu, i_instr_xor;
  logic i_instr_srl, i_instr_sra, i_instr_or, i_instr_and;
  logic i_instr_rdcycle, i_instr_rdcycleh, i_instr_rdinstr, i_instr_rdinstrh, i_instr_ecall_ebreak;
  logic i_instr_getq, i_instr_setq, i_instr_retirq, i_instr_maskirq, i_instr_waitirq, i_instr_timer, i_instr_trap;
  logic [31:0] i_pc, i_next_pc;
  logic        i_dbg_next;

  logic ev_lui, ev_auipc, ev_jal, ev_jalr;
  logic ev_beq, ev_bne, ev_blt, ev_bge, ev_bltu, ev_bgeu;
  logic ev_lb, ev_lh, ev_lw, ev_lbu, ev_lhu, ev_sb, ev_sh, ev_sw;
  logic ev_addi, ev_slti, ev_sltiu, ev_xori, ev_ori, ev_andi, ev_slli, ev_srli, ev_srai;
  logic ev_add, ev_sub, ev_sll, ev_slt, ev_sltu, ev_xor, ev_srl, ev_sra, ev_or, ev_and;
  logic ev_rdcycle, ev_rdcycleh, ev_rdinstr, ev_rdinstrh, ev_ecall_ebreak;
  logic ev_getq, ev_setq, ev_retirq, ev_maskirq, ev_waitirq, ev_timer, ev_trap;
  logic ev_branch, ev_jump, ev_load, ev_store, ev_alu, ev_system, ev_irq;
  logic ev_unknown, ev_multi, ev_misalign, ev_nonseq;

  mnem_vec_t instr_vec;
  ev_vec_t   ev_vec;

  assign instr_vec = {
    i_instr_trap, i_instr_timer, i_instr_waitirq, i_instr_maskirq, i_instr_retirq, i_instr_setq, i_instr_getq,
    i_instr_ecall_ebreak, i_instr_rdinstrh, i_instr_rdinstr, i_instr_rdcycleh, i_instr_rdcycle,
    i_instr_and, i_instr_or, i_instr_sra, i_instr_srl, i_instr_xor, i_instr_sltu, i_instr_slt,
    i_instr_sll, i_instr_sub, i_instr_add,
    i_instr_srai, i_instr_srli, i_instr_slli, i_instr_andi, i_instr_ori, i_instr_xori,
    i_instr_sltiu, i_instr_slti, i_instr_addi,
    i_instr_sw, i_instr_sh, i_instr_sb, i_instr_lhu, i_instr_lbu, i_instr_lw, i_instr_lh, i_instr_lb,
    i_instr_bgeu, i_instr_bltu, i_instr_bge, i_instr_blt, i_instr_bne, i_instr_beq,
    i_instr_jalr, i_instr_jal, i_instr_auipc, i_instr_lui};

  assign {
    ev_nonseq, ev_misalign, ev_multi, ev_unknown,
    ev_irq, ev_system, ev_alu, ev_store, ev_load, ev_jump, ev_branch,
    ev_trap, ev_timer, ev_waitirq, ev_maskirq, ev_retirq, ev_setq, ev_getq,
    ev_ecall_ebreak, ev_rdinstrh, ev_rdinstr, ev_rdcycleh, ev_rdcycle,
    ev_and, ev_or, ev_sra, ev_srl, ev_xor, ev_sltu, ev_slt, ev_sll, ev_sub, ev_add,
    ev_srai, ev_srli, ev_slli, ev_andi, ev_ori, ev_xori, ev_sltiu, ev_slti, ev_addi,
    ev_sw, ev_sh, ev_sb, ev_lhu, ev_lbu, ev_lw, ev_lh, ev_lb,
    ev_bgeu, ev_bltu, ev_bge, ev_blt, ev_bne, ev_beq,
    ev_jalr, ev_jal, ev_auipc, ev_lui} = ev_vec;

  modport slave (
    input  instr_vec, i_pc, i_next_pc, i_dbg_next,
    output ev_vec
  );

  modport master (
    output i_instr_lui, i_instr_auipc, i_instr_jal, i_instr_jalr,
           i_instr_beq, i_instr_bne, i_instr_blt, i_instr_bge, i_instr_bltu, i_instr_bgeu,
           i_instr_lb, i_instr_lh, i_instr_lw, i_instr_lbu, i_instr_lhu, i_instr_sb, i_instr_sh, i_instr_sw,
           i_instr_addi, i_instr_slti, i_instr_sltiu, i_instr_xori, i_instr_ori, i_instr_andi,
           i_instr_slli, i_instr_srli, i_instr_srai,
           i_instr_add, i_instr_sub, i_instr_sll, i_instr_slt, i_instr_sltu, i_instr_xor,
           i_instr_srl, i_instr_sra, i_instr_or, i_instr_and,
           i_instr_rdcycle, i_instr_rdcycleh, i_instr_rdinstr, i_instr_rdinstrh, i_instr_ecall_ebreak,
           i_instr_getq, i_instr_setq, i_instr_retirq, i_instr_maskirq, i_instr_waitirq, i_instr_timer,
           i_instr_trap, i_pc, i_next_pc, i_dbg_next,
    input  ev_lui, ev_auipc, ev_jal, ev_jalr, ev_beq, ev_bne, ev_blt, ev_bge, ev_bltu, ev_bgeu,
           ev_lb, ev_lh, ev_lw, ev_lbu, ev_lhu, ev_sb, ev_sh, ev_sw,
           ev_addi, ev_slti, ev_sltiu, ev_xori, ev_ori, ev_andi, ev_slli, ev_srli, ev_srai,
           ev_add, ev_sub, ev_sll, ev_slt, ev_sltu, ev_xor, ev_srl, ev_sra, ev_or, ev_and,
           ev_rdcycle, ev_rdcycleh, ev_rdinstr, ev_rdinstrh, ev_ecall_ebreak,
           ev_getq, ev_setq, ev_retirq, ev_maskirq, ev_waitirq, ev_timer, ev_trap,
           ev_branch, ev_jump, ev_load, ev_store, ev_alu, ev_system, ev_irq,
           ev_unknown, ev_multi, ev_misalign, ev_nonseq
  );

endinterface

// File: rtl/evmon_pulse.sv
// One registered event: fires for a single cycle after an issue that had
// its condition bit set.
module evmon_pulse (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_issue,
    input  logic i_bit,
    output logic o_ev
);

    // NOTE: non-blocking, so every event register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_rst) o_ev <= 1'b0;
        else        o_ev <= i_issue & i_bit;
    end

endmodule

// File: rtl/riscvsys_evmon.sv
// Instruction event monitor: turns per-issue decode flags and PCs into
// registered one-cycle event pulses plus a retired-instruction counter.
module riscvsys_evmon
    import riscvsys_evmon_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    riscvsys_evmon_if.slave    bus,
    output logic [CNT_W-1:0]   o_retired
);

    logic        issue;
    mnem_vec_t   flags;
    logic [31:0] pc_plus2, pc_plus4;
    ev_vec_t     ev_raw, ev_q;

    assign issue    = bus.i_dbg_next;
    assign flags    = bus.instr_vec;
    assign pc_plus2 = bus.i_pc + 32'd2;
    assign pc_plus4 = bus.i_pc + 32'd4;

    // Unqualified event conditions; issue gating happens inside each pulse register.
    always_comb begin
        // NOTE: full default first so no branch can leave bits unassigned.
        ev_raw                = '0;
        ev_raw[N_MNEM-1:0]    = flags;
        ev_raw[EV_BRANCH]     = |(flags & MASK_BRANCH);
        ev_raw[EV_JUMP]       = |(flags & MASK_JUMP);
        ev_raw[EV_LOAD]       = |(flags & MASK_LOAD);
        ev_raw[EV_STORE]      = |(flags & MASK_STORE);
        ev_raw[EV_ALU]        = |(flags & MASK_ALU);
        ev_raw[EV_SYSTEM]     = |(flags & MASK_SYSTEM);
        ev_raw[EV_IRQ]        = |(flags & MASK_IRQ);
        ev_raw[EV_UNKNOWN]    = (flags == '0);
        ev_raw[EV_MULTI]      = ($countones(flags) > 1);
        ev_raw[EV_MISALIGN]   = bus.i_pc[0];
        ev_raw[EV_NONSEQ]     = (bus.i_next_pc != pc_plus2) && (bus.i_next_pc != pc_plus4);
    end

    for (genvar g = 0; g < N_EV; g++) begin : g_pulse
        evmon_pulse u_pulse (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_issue (issue),
            .i_bit   (ev_raw[g]),
            .o_ev    (ev_q[g])
        );
    end

    assign bus.ev_vec = ev_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst)     o_retired <= '0;
        else if (issue) o_retired <= o_retired + CNT_W'(1);
    end

endmodule

// File: tb/tb_riscvsys_evmon.sv
// Directed self-checking bench for riscvsys_evmon: events, class ORs,
// status flags, PC wrap, reset behaviour and counter wrap.
module tb_riscvsys_evmon;

    localparam int B_LUI = 0, B_AUIPC = 1, B_JAL = 2, B_JALR = 3, B_BEQ = 4;
    localparam int B_LW = 12, B_LBU = 13, B_SW = 17, B_XORI = 21, B_ADD = 27;
    localparam int B_ECALL = 41, B_GETQ = 42, B_TIMER = 47, B_TRAP = 48;
    localparam int B_BRANCH = 49, B_JUMP = 50, B_LOAD = 51, B_STORE = 52, B_ALU = 53;
    localparam int B_SYSTEM = 54, B_IRQ = 55, B_UNK = 56, B_MULTI = 57, B_MIS = 58, B_NONSEQ = 59;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic [31:0] retired;
    logic [3:0]  retired4;
    int          n_chk = 0;
    int          n_bad = 0;

    riscvsys_evmon_if bus ();
    riscvsys_evmon_if bus4 ();

    riscvsys_evmon #(.CNT_W(32)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .bus(bus), .o_retired(retired));

    riscvsys_evmon #(.CNT_W(4)) dut4 (
        .i_clk(i_clk), .i_rst(i_rst), .bus(bus4), .o_retired(retired4));

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    function automatic logic [48:0] fl(input int i);
        logic [48:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [63:0] ev(input int i);
        logic [63:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [63:0] obs_ev();
        return {4'b0,
            bus.ev_nonseq, bus.ev_misalign, bus.ev_multi, bus.ev_unknown,
            bus.ev_irq, bus.ev_system, bus.ev_alu, bus.ev_store, bus.ev_load, bus.ev_jump, bus.ev_branch,
            bus.ev_trap, bus.ev_timer, bus.ev_waitirq, bus.ev_maskirq, bus.ev_retirq, bus.ev_setq, bus.ev_getq,
            bus.ev_ecall_ebreak, bus.ev_rdinstrh, bus.ev_rdinstr, bus.ev_rdcycleh, bus.ev_rdcycle,
            bus.ev_and, bus.ev_or, bus.ev_sra, bus.ev_srl, bus.ev_xor, bus.ev_sltu, bus.ev_slt,
            bus.ev_sll, bus.ev_sub, bus.ev_add,
            bus.ev_srai, bus.ev_srli, bus.ev_slli, bus.ev_andi, bus.ev_ori, bus.ev_xori,
            bus.ev_sltiu, bus.ev_slti, bus.ev_addi,
            bus.ev_sw, bus.ev_sh, bus.ev_sb, bus.ev_lhu, bus.ev_lbu, bus.ev_lw, bus.ev_lh, bus.ev_lb,
            bus.ev_bgeu, bus.ev_bltu, bus.ev_bge, bus.ev_blt, bus.ev_bne, bus.ev_beq,
            bus.ev_jalr, bus.ev_jal, bus.ev_auipc, bus.ev_lui};
    endfunction

    task automatic set_flags(input logic [48:0] f);
        {bus.i_instr_trap, bus.i_instr_timer, bus.i_instr_waitirq, bus.i_instr_maskirq,
         bus.i_instr_retirq, bus.i_instr_setq, bus.i_instr_getq,
         bus.i_instr_ecall_ebreak, bus.i_instr_rdinstrh, bus.i_instr_rdinstr,
         bus.i_instr_rdcycleh, bus.i_instr_rdcycle,
         bus.i_instr_and, bus.i_instr_or, bus.i_instr_sra, bus.i_instr_srl, bus.i_instr_xor,
         bus.i_instr_sltu, bus.i_instr_slt, bus.i_instr_sll, bus.i_instr_sub, bus.i_instr_add,
         bus.i_instr_srai, bus.i_instr_srli, bus.i_instr_slli, bus.i_instr_andi, bus.i_instr_ori,
         bus.i_instr_xori, bus.i_instr_sltiu, bus.i_instr_slti, bus.i_instr_addi,
         bus.i_instr_sw, bus.i_instr_sh, bus.i_instr_sb, bus.i_instr_lhu, bus.i_instr_lbu,
         bus.i_instr_lw, bus.i_instr_lh, bus.i_instr_lb,
         bus.i_instr_bgeu, bus.i_instr_bltu, bus.i_instr_bge, bus.i_instr_blt, bus.i_instr_bne,
         bus.i_instr_beq, bus.i_instr_jalr, bus.i_instr_jal, bus.i_instr_auipc, bus.i_instr_lui} = f;
    endtask

    task automatic issue(input logic [48:0] f, input logic [31:0] pc, input logic [31:0] npc);
        set_flags(f);
        bus.i_pc       = pc;
        bus.i_next_pc  = npc;
        bus.i_dbg_next = 1'b1;
    endtask

    task automatic idle();
        set_flags('0);
        bus.i_dbg_next = 1'b0;
    endtask

    // One clock; returns on the falling edge so outputs are stable for checking.
    task automatic step();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic expect_ev(input string tag, input logic [63:0] want, input int want_cnt);
        check({tag, " ev"}, obs_ev(), want);
        check({tag, " retired"}, 64'(retired), 64'(want_cnt));
    endtask

    initial begin
        idle();
        bus.i_pc = '0;
        bus.i_next_pc = '0;
        {bus4.i_instr_trap, bus4.i_instr_timer, bus4.i_instr_waitirq, bus4.i_instr_maskirq,
         bus4.i_instr_retirq, bus4.i_instr_setq, bus4.i_instr_getq,
         bus4.i_instr_ecall_ebreak, bus4.i_instr_rdinstrh, bus4.i_instr_rdinstr,
         bus4.i_instr_rdcycleh, bus4.i_instr_rdcycle,
         bus4.i_instr_and, bus4.i_instr_or, bus4.i_instr_sra, bus4.i_instr_srl, bus4.i_instr_xor,
         bus4.i_instr_sltu, bus4.i_instr_slt, bus4.i_instr_sll, bus4.i_instr_sub, bus4.i_instr_add,
         bus4.i_instr_srai, bus4.i_instr_srli, bus4.i_instr_slli, bus4.i_instr_andi, bus4.i_instr_ori,
         bus4.i_instr_xori, bus4.i_instr_sltiu, bus4.i_instr_slti, bus4.i_instr_addi,
         bus4.i_instr_sw, bus4.i_instr_sh, bus4.i_instr_sb, bus4.i_instr_lhu, bus4.i_instr_lbu,
         bus4.i_instr_lw, bus4.i_instr_lh, bus4.i_instr_lb,
         bus4.i_instr_bgeu, bus4.i_instr_bltu, bus4.i_instr_bge, bus4.i_instr_blt, bus4.i_instr_bne,
         bus4.i_instr_beq, bus4.i_instr_jalr, bus4.i_instr_jal, bus4.i_instr_auipc, bus4.i_instr_lui} = '0;
        bus4.i_pc = 32'h0;
        bus4.i_next_pc = 32'h4;
        bus4.i_dbg_next = 1'b0;

        repeat (3) step();
        expect_ev("reset", 64'h0, 0);
        check("reset retired4", 64'(retired4), 64'd0);
        i_rst = 1'b1;

        issue(fl(B_ADD), 32'h100, 32'h104); step();
        expect_ev("add", ev(B_ADD) | ev(B_ALU), 1);
        check("ev_add pin", 64'(bus.ev_add), 64'd1);
        idle(); step();
        expect_ev("add drop", 64'h0, 1);

        issue(fl(B_BEQ), 32'h200, 32'h180); step();
        expect_ev("beq taken", ev(B_BEQ) | ev(B_BRANCH) | ev(B_NONSEQ), 2);
        issue(fl(B_BEQ), 32'h200, 32'h202); step();
        expect_ev("beq seq2", ev(B_BEQ) | ev(B_BRANCH), 3);

        set_flags(fl(B_LW));
        bus.i_dbg_next = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("lw no issue", obs_ev(), 64'h0);
        end
        check("lw no issue retired", 64'(retired), 64'd3);

        issue('0, 32'h101, 32'h105); step();
        expect_ev("unknown misalign", ev(B_UNK) | ev(B_MIS), 4);
        issue(fl(B_SW) | fl(B_XORI), 32'h300, 32'h304); step();
        expect_ev("multi", ev(B_SW) | ev(B_XORI) | ev(B_STORE) | ev(B_ALU) | ev(B_MULTI), 5);

        issue(fl(B_JALR), 32'hFFFF_FFFE, 32'h0000_0002); step();
        expect_ev("pc wrap +4", ev(B_JALR) | ev(B_JUMP), 6);
        issue(fl(B_JAL), 32'hFFFF_FFFE, 32'h0000_0000); step();
        expect_ev("pc wrap +2", ev(B_JAL) | ev(B_JUMP), 7);
        issue(fl(B_JAL), 32'hFFFF_FFFC, 32'h0000_0004); step();
        expect_ev("pc wrap +8", ev(B_JAL) | ev(B_JUMP) | ev(B_NONSEQ), 8);

        issue(fl(B_TRAP), 32'h400, 32'h404); step();
        expect_ev("trap", ev(B_TRAP), 9);
        issue(fl(B_ECALL), 32'h404, 32'h408); step();
        expect_ev("ecall", ev(B_ECALL) | ev(B_SYSTEM), 10);
        issue(fl(B_GETQ), 32'h408, 32'h40C); step();
        expect_ev("getq", ev(B_GETQ) | ev(B_IRQ), 11);

        idle();
        i_rst = 1'b0; step();
        i_rst = 1'b1;
        expect_ev("re-reset", 64'h0, 0);

        issue(fl(B_LUI), 32'h10, 32'h14); step();
        expect_ev("b2b lui", ev(B_LUI) | ev(B_ALU), 1);
        issue(fl(B_AUIPC), 32'h14, 32'h18); step();
        expect_ev("b2b auipc", ev(B_AUIPC) | ev(B_ALU), 2);
        issue(fl(B_JAL), 32'h18, 32'h1C); step();
        expect_ev("b2b jal", ev(B_JAL) | ev(B_JUMP), 3);
        issue(fl(B_LBU), 32'h1C, 32'h20); step();
        expect_ev("b2b lbu", ev(B_LBU) | ev(B_LOAD), 4);
        issue(fl(B_TIMER), 32'h20, 32'h24); step();
        expect_ev("b2b timer", ev(B_TIMER) | ev(B_IRQ), 5);

        issue(fl(B_LUI), 32'h24, 32'h28);
        i_rst = 1'b0; step();
        expect_ev("issue in reset", 64'h0, 0);
        i_rst = 1'b1; step();
        expect_ev("first after reset", ev(B_LUI) | ev(B_ALU), 1);
        idle();

        bus4.i_dbg_next = 1'b1;
        repeat (15) step();
        check("cnt4 at 15", 64'(retired4), 64'd15);
        step();
        check("cnt4 wrap 0", 64'(retired4), 64'd0);
        step();
        check("cnt4 after 17", 64'(retired4), 64'd1);
        bus4.i_dbg_next = 1'b0;
        step();
        check("cnt4 hold", 64'(retired4), 64'd1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
